// File: rtl/cordic_arb_pkg.sv
// Shared types and defaults for the two-requester CORDIC arbiter.
package cordic_arb_pkg;

    localparam int ANGLE_W_DEF = 9;
    localparam int DATA_W_DEF  = 11;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_GUARD,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef logic req_id_t;
    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

endpackage

// File: rtl/cordic_arbiter_if.sv
// Requester and core-side signals of the CORDIC arbiter, bundled for port lists.
interface cordic_arbiter_if #(
    parameter int ANGLE_W = cordic_arb_pkg::ANGLE_W_DEF,
    parameter int DATA_W  = cordic_arb_pkg::DATA_W_DEF
);
    logic                      req0;
    logic                      req1;
    logic        [ANGLE_W-1:0] angle0;
    logic        [ANGLE_W-1:0] angle1;
    logic                      ack0;
    logic                      ack1;
    logic                      rvalid0;
    logic                      rvalid1;
    logic signed [DATA_W-1:0]  cos_out;
    logic signed [DATA_W-1:0]  sin_out;
    logic                      err;
    logic                      busy;
    logic                      core_start;
    logic        [ANGLE_W-1:0] core_z0;
    logic                      core_done;
    logic signed [DATA_W-1:0]  core_cos;
    logic signed [DATA_W-1:0]  core_sin;

    // master: the arbiter itself; slave: requesters plus the CORDIC core.
    modport master (
        input  req0, req1, angle0, angle1, core_done, core_cos, core_sin,
        output ack0, ack1, rvalid0, rvalid1, cos_out, sin_out, err, busy,
               core_start, core_z0
    );

    modport slave (
        output req0, req1, angle0, angle1, core_done, core_cos, core_sin,
        input  ack0, ack1, rvalid0, rvalid1, cos_out, sin_out, err, busy,
               core_start, core_z0
    );

endinterface

// File: rtl/cordic_rr_pick.sv
// Combinational two-way round-robin select: the requester that did not win last time wins a tie.
module cordic_rr_pick
    import cordic_arb_pkg::*;
(
    input  logic    req0,
    input  logic    req1,
    input  req_id_t last_grant,
    output logic    grant_valid,
    output req_id_t grant_id
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the block can infer a latch.
        grant_valid = req0 | req1;
        grant_id    = REQ0;
        if (req0 && req1) begin
            grant_id = (last_grant == REQ0) ? REQ1 : REQ0;
        end else if (req1) begin
            grant_id = REQ1;
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Arbitrates two requesters onto one cordic_prop core: grant, start, guarded wait with timeout,
// and return of the captured cos/sin to the granted requester. All outputs are registered.
module cordic_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int ANGLE_W = ANGLE_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk_50,
    input  logic             Reset,
    cordic_arbiter_if.master bus
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_e                    state_q;
    req_id_t                   last_grant_q;
    req_id_t                   grant_id_q;
    logic                      ack0_q;
    logic                      ack1_q;
    logic                      rvalid0_q;
    logic                      rvalid1_q;
    logic signed [DATA_W-1:0]  cos_q;
    logic signed [DATA_W-1:0]  sin_q;
    logic                      err_q;
    logic                      busy_q;
    logic                      core_start_q;
    logic        [ANGLE_W-1:0] z0_q;
    logic        [CNT_W-1:0]   cnt_q;
    logic                      expired_q;

    logic                      grant_valid;
    req_id_t                   grant_id;

    cordic_rr_pick u_pick (
        .req0        (bus.req0),
        .req1        (bus.req1),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk_50 or negedge Reset) begin
        if (!Reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q      <= ST_IDLE;
            last_grant_q <= REQ1;
            grant_id_q   <= REQ0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            cos_q        <= '0;
            sin_q        <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            core_start_q <= 1'b0;
            z0_q         <= '0;
            cnt_q        <= '0;
            expired_q    <= 1'b0;
        end else begin
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        state_q      <= ST_START;
                        grant_id_q   <= grant_id;
                        last_grant_q <= grant_id;
                        z0_q         <= (grant_id == REQ1) ? bus.angle1 : bus.angle0;
                        ack0_q       <= (grant_id == REQ0);
                        ack1_q       <= (grant_id == REQ1);
                        busy_q       <= 1'b1;
                    end
                end

                // First cycle raises the registered start; the second, with start visible, drops it.
                ST_START: begin
                    if (!core_start_q) begin
                        core_start_q <= 1'b1;
                    end else begin
                        core_start_q <= 1'b0;
                        state_q      <= ST_GUARD;
                    end
                end

                ST_GUARD: begin
                    cnt_q     <= '0;
                    expired_q <= 1'b0;
                    state_q   <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (bus.core_done) begin
                        cos_q     <= bus.core_cos;
                        sin_q     <= bus.core_sin;
                        rvalid0_q <= (grant_id_q == REQ0);
                        rvalid1_q <= (grant_id_q == REQ1);
                        state_q   <= ST_RESP;
                    end else if (expired_q) begin
                        err_q     <= 1'b1;
                        cos_q     <= '0;
                        sin_q     <= '0;
                        rvalid0_q <= (grant_id_q == REQ0);
                        rvalid1_q <= (grant_id_q == REQ1);
                        state_q   <= ST_RESP;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        expired_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    core_start_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack0       = ack0_q;
    assign bus.ack1       = ack1_q;
    assign bus.rvalid0    = rvalid0_q;
    assign bus.rvalid1    = rvalid1_q;
    assign bus.cos_out    = cos_q;
    assign bus.sin_out    = sin_q;
    assign bus.err        = err_q;
    assign bus.busy       = busy_q;
    assign bus.core_start = core_start_q;
    assign bus.core_z0    = z0_q;

endmodule

// File: doc/cordic_arbiter.md
# cordic_arbiter

Two-requester round-robin arbiter and sequencer for a single shared `cordic_prop` core. Each requester presents a 9-bit angle with a request. The block grants one requester, drives the core's `start`/`z0`, waits for `done` with a timeout, and returns the captured cos/sin to the granted requester. It sits between the board-level control logic and `cordic_prop`, replacing direct button-driven start.

## Interface
Parameters:
- `ANGLE_W`, 9, angle width (matches `cordic_prop.z0`)
- `DATA_W`, 11, signed result width (matches `cos_z0`/`sin_z0`)
- `TIMEOUT`, 64, max cycles in WAIT before abort (>= 2)

Ports:
- `clk_50`  in  1  single clock; all logic rising-edge
- `Reset`  in  1  asynchronous, active-low reset
- `req0`, `req1`  in  1  request level per requester
- `angle0`, `angle1`  in  ANGLE_W  angle, sampled on grant
- `ack0`, `ack1`  out  1  one-cycle pulse: request accepted, angle latched
- `rvalid0`, `rvalid1`  out  1  one-cycle pulse: result for that requester on `cos_out`/`sin_out`
- `cos_out`, `sin_out`  out  DATA_W signed  shared result bus, held until next result
- `err`  out  1  sticky timeout flag
- `busy`  out  1  high in any state except IDLE
- `core_start`  out  1  to `cordic_prop.start`
- `core_z0`  out  ANGLE_W  to `cordic_prop.z0`, stable from grant to result
- `core_done`  in  1  from `cordic_prop.done`
- `core_cos`, `core_sin`  in  DATA_W signed  from core

## Operation
- Reset values: all outputs 0; `last_grant`=1 so requester 0 wins first contention; state IDLE; timeout counter 0.
- FSM states:
  - IDLE: if any req, pick winner → START. Otherwise stay.
  - START: `core_start`=1 for exactly one cycle → GUARD.
  - GUARD: one cycle, `core_done` ignored so that a stale `done` level from the previous op is not taken → WAIT.
  - WAIT: counter increments each cycle. On the first cycle with `core_done`=1, capture `core_cos`/`core_sin` → RESP. If counter reaches TIMEOUT-1 without `done`, set `err`, load results with 0 → RESP.
  - RESP: pulse `rvalid` of the granted requester → IDLE.
- Arbitration, evaluated in IDLE only:
  - Exactly one req: grant it.
  - Both reqs: grant the one ≠ `last_grant`.
  - Update `last_grant` on the grant.
- On the grant cycle (IDLE→START edge): register winner id, `core_z0`←winner's angle, pulse winner's `ack`.
- A requester deasserting req after `ack` does not cancel the operation; the result is still delivered.
- A req still high in the cycle after its `rvalid` is treated as a new request.
- `err` clears only on `Reset`. Operation continues normally after a timeout.
- Reset asserted mid-operation: immediately returns to IDLE, `core_start` low, no `rvalid` emitted, pending grant discarded.
- No arithmetic on results; pass-through, signed DATA_W.

## Timing
- Cycle 0 (IDLE, req sampled): `ack` pulses at cycle 0 output register edge, i.e. visible in cycle 1. `core_z0` valid from cycle 1.
- `core_start` high in cycle 2. GUARD is cycle 3. WAIT starts at cycle 4.
- With `done` first seen in WAIT at cycle N, `cos_out`/`sin_out` update and `rvalid` are visible at N+1. A new grant is possible with IDLE at N+2.
- Minimum op-to-op spacing: 5 cycles plus core latency.
- A timeout result appears TIMEOUT cycles after WAIT entry, plus 1.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- `cordic_arb_pkg`: ANGLE_W/DATA_W defaults, FSM state encoding (IDLE, START, GUARD, WAIT, RESP), requester-id constants.
- Sub-module `cordic_rr_pick`: combinational 2-way round-robin select (`req0`, `req1`, `last_grant` → `grant_valid`, `grant_id`). Kept separate for reuse when requester count grows.
- Top block owns FSM, timeout counter, angle/result registers.

## Test plan
- Single request: `req0`=1, `angle0`=9'd90, core model returns done after 16 cycles with cos=0, sin=11'sd511 → `ack0` cycle 1, `core_start` cycle 2, `rvalid0` with sin_out=511, cos_out=0; `rvalid1` never.
- Contention: `req0`=`req1`=1 held → grants alternate 0,1,0,1 across four ops; each `rvalid` matches its own angle's model result.
- Stale done: core model holds `done`=1 continuously between ops → second op still waits for GUARD, takes result only from the WAIT cycle, `core_start` pulsed exactly once per op.
- Timeout: TIMEOUT=8, core never asserts done → `rvalid0` with cos=sin=0 at 9 cycles after WAIT entry, `err`=1 and stays 1; next op with working core completes normally.
- Reset mid-op: assert `Reset`=0 during WAIT → all outputs 0 asynchronously, no `rvalid`. After release, `req1` alone → granted first op.
- Req withdrawn: `req0` drops the cycle after `ack0` → result still delivered via `rvalid0`.
